// File: rtl/pwm_breath_ctr_pkg.sv
// Shared definitions for the LED breathing sequencer: state encoding,
// duty scale and the millisecond prescaler divisor.
package pwm_breath_ctr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

  localparam logic [9:0]  DUTY_FULL  = 10'd100;
  localparam int unsigned MS_PER_MHZ = 1000;

  // Clock cycles per millisecond for a clock given in MHz.
  function automatic int unsigned ms_div(input int unsigned clk_fre);
    return clk_fre * MS_PER_MHZ;
  endfunction

endpackage

// File: rtl/pwm_breath_ctr_ms_tick.sv
// Millisecond prescaler: counts 0..DIV-1 while clr is low and flags the
// terminal count for one clock before wrapping.
module ms_tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TC = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Terminal count is decoded straight from the register so the tick never
  // depends on clr (clr itself is derived from the FSM, which uses tick).
  assign tick = (cnt_q == TC);

  // Next prescaler value: held at zero while cleared, wraps on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_breath_ctr.sv
// LED breathing sequencer feeding duty and rate to a PWM generator.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | output off; waits for en, then latches the configuration
// ST_RISE    | duty climbs by step_c every step_ms until it reaches max_c
// ST_HOLD_HI | dwell at max_c for hold_hi_ms (0 = one clock)
// ST_FALL    | duty drops by step_c every step_ms until it reaches min_c
// ST_HOLD_LO | dwell at min_c for hold_lo_ms, then end-of-cycle pulse
import pwm_breath_ctr_pkg::*;

module pwm_breath_ctr #(
  parameter int unsigned CLK_FRE  = 50,
  parameter int unsigned PWM_RATE = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        one_shot,
  input  logic [9:0]  duty_min,
  input  logic [9:0]  duty_max,
  input  logic [6:0]  duty_step,
  input  logic [15:0] step_ms,
  input  logic [15:0] hold_hi_ms,
  input  logic [15:0] hold_lo_ms,
  output logic [9:0]  pwm_duty,
  output logic [20:0] pwm_rate,
  output logic        busy,
  output logic        cycle_done
);

  localparam int unsigned MS_DIV = ms_div(CLK_FRE);

  state_e      state_q, state_d;
  logic [9:0]  duty_q, duty_d;
  logic [9:0]  min_c_q, min_c_d;
  logic [9:0]  max_c_q, max_c_d;
  logic [6:0]  step_c_q, step_c_d;
  logic [15:0] step_ms_c_q, step_ms_c_d;
  logic [15:0] hold_hi_c_q, hold_hi_c_d;
  logic [15:0] hold_lo_c_q, hold_lo_c_d;
  logic        one_shot_c_q, one_shot_c_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;

  logic        tick;
  logic        restart;
  logic        expire;
  logic [15:0] interval;
  logic [9:0]  max_in, min_in;
  logic [10:0] rise_sum, fall_floor;
  logic [9:0]  rise_val, fall_val;

  assign pwm_rate   = 21'(PWM_RATE);
  assign pwm_duty   = duty_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;

  ms_tick_gen #(.DIV(MS_DIV)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .tick  (tick)
  );

  // Sanitised configuration as it would be captured at start.
  always_comb begin
    max_in = (duty_max > DUTY_FULL) ? DUTY_FULL : duty_max;
    min_in = (duty_min > max_in) ? max_in : duty_min;
  end

  // Interval of the current state and its expiry; a zero-length hold
  // expires on the first clock spent in the state.
  always_comb begin
    interval = 16'd0;
    case (state_q)
      ST_RISE, ST_FALL: interval = step_ms_c_q;
      ST_HOLD_HI:       interval = hold_hi_c_q;
      ST_HOLD_LO:       interval = hold_lo_c_q;
      default:          interval = 16'd0;
    endcase
    expire = (state_q != ST_IDLE) &&
             ((interval == 16'd0) || (tick && (ms_cnt_q == interval - 16'd1)));
  end

  // Clamped step results, computed one bit wider so the sum cannot wrap.
  always_comb begin
    rise_sum   = {1'b0, duty_q} + {4'b0, step_c_q};
    rise_val   = (rise_sum > {1'b0, max_c_q}) ? max_c_q : rise_sum[9:0];
    fall_floor = {1'b0, min_c_q} + {4'b0, step_c_q};
    fall_val   = ({1'b0, duty_q} <= fall_floor) ? min_c_q : (duty_q - {3'b0, step_c_q});
  end

  // Next-state, duty and shadow configuration; en low overrides everything.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    min_c_d      = min_c_q;
    max_c_d      = max_c_q;
    step_c_d     = step_c_q;
    step_ms_c_d  = step_ms_c_q;
    hold_hi_c_d  = hold_hi_c_q;
    hold_lo_c_d  = hold_lo_c_q;
    one_shot_c_d = one_shot_c_q;
    done_d       = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      duty_d  = 10'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          max_c_d      = max_in;
          min_c_d      = min_in;
          step_c_d     = (duty_step == 7'd0) ? 7'd1 : duty_step;
          step_ms_c_d  = (step_ms == 16'd0) ? 16'd1 : step_ms;
          hold_hi_c_d  = hold_hi_ms;
          hold_lo_c_d  = hold_lo_ms;
          one_shot_c_d = one_shot;
          duty_d       = min_in;
          state_d      = ST_RISE;
        end
        ST_RISE: begin
          if (expire) begin
            duty_d = rise_val;
            if (rise_val == max_c_q) state_d = ST_HOLD_HI;
          end
        end
        ST_HOLD_HI: begin
          if (expire) state_d = ST_FALL;
        end
        ST_FALL: begin
          if (expire) begin
            duty_d = fall_val;
            if (fall_val == min_c_q) state_d = ST_HOLD_LO;
          end
        end
        ST_HOLD_LO: begin
          if (expire) begin
            done_d = 1'b1;
            if (one_shot_c_q) begin
              state_d = ST_IDLE;
              duty_d  = 10'd0;
            end else begin
              state_d = ST_RISE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = 10'd0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Both timers restart on every state change and stay parked in IDLE, so
  // each state always gets its full interval.
  always_comb begin
    restart = (state_d != state_q) || (state_q == ST_IDLE);
    if (restart || expire) begin
      ms_cnt_d = 16'd0;
    end else if (tick) begin
      ms_cnt_d = ms_cnt_q + 16'd1;
    end else begin
      ms_cnt_d = ms_cnt_q;
    end
  end

  // State, output and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      duty_q       <= 10'd0;
      min_c_q      <= 10'd0;
      max_c_q      <= 10'd0;
      step_c_q     <= 7'd0;
      step_ms_c_q  <= 16'd0;
      hold_hi_c_q  <= 16'd0;
      hold_lo_c_q  <= 16'd0;
      one_shot_c_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ms_cnt_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      min_c_q      <= min_c_d;
      max_c_q      <= max_c_d;
      step_c_q     <= step_c_d;
      step_ms_c_q  <= step_ms_c_d;
      hold_hi_c_q  <= hold_hi_c_d;
      hold_lo_c_q  <= hold_lo_c_d;
      one_shot_c_q <= one_shot_c_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ms_cnt_q     <= ms_cnt_d;
    end
  end

endmodule

// File: tb/tb_pwm_breath_ctr.sv
// Self-checking bench for pwm_breath_ctr with a cycle-countdown reference
// model of the breathing profile.
module tb_pwm_breath_ctr;

  localparam int CLK_FRE  = 1;
  localparam int PWM_RATE = 1000;
  localparam int MS       = CLK_FRE * 1000;

  localparam int M_IDLE = 0;
  localparam int M_RISE = 1;
  localparam int M_HH   = 2;
  localparam int M_FALL = 3;
  localparam int M_HL   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        one_shot = 1'b0;
  logic [9:0]  duty_min = '0;
  logic [9:0]  duty_max = '0;
  logic [6:0]  duty_step = '0;
  logic [15:0] step_ms = '0;
  logic [15:0] hold_hi_ms = '0;
  logic [15:0] hold_lo_ms = '0;
  logic [9:0]  pwm_duty;
  logic [20:0] pwm_rate;
  logic        busy;
  logic        cycle_done;

  pwm_breath_ctr #(.CLK_FRE(CLK_FRE), .PWM_RATE(PWM_RATE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .one_shot   (one_shot),
    .duty_min   (duty_min),
    .duty_max   (duty_max),
    .duty_step  (duty_step),
    .step_ms    (step_ms),
    .hold_hi_ms (hold_hi_ms),
    .hold_lo_ms (hold_lo_ms),
    .pwm_duty   (pwm_duty),
    .pwm_rate   (pwm_rate),
    .busy       (busy),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each phase is a countdown of clock cycles.
  int m_mode = M_IDLE, m_duty = 0, m_busy = 0, m_done = 0, m_left = 0;
  int m_min = 0, m_max = 0, m_step = 1, m_sms = 1, m_hh = 0, m_hl = 0, m_os = 0;

  function automatic int span(input int ms);
    return (ms == 0) ? 1 : ms * MS;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_duty = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      cyc++;
      m_done = 0;
      if (!en) begin
        m_mode = M_IDLE;
        m_duty = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            m_max  = (int'(duty_max) > 100) ? 100 : int'(duty_max);
            m_min  = (int'(duty_min) > m_max) ? m_max : int'(duty_min);
            m_step = (duty_step == 0) ? 1 : int'(duty_step);
            m_sms  = (step_ms == 0) ? 1 : int'(step_ms);
            m_hh   = int'(hold_hi_ms);
            m_hl   = int'(hold_lo_ms);
            m_os   = int'(one_shot);
            m_duty = m_min;
            m_mode = M_RISE;
            m_left = m_sms * MS;
          end
          M_RISE: begin
            m_left--;
            if (m_left == 0) begin
              m_duty = (m_duty + m_step > m_max) ? m_max : m_duty + m_step;
              if (m_duty == m_max) begin m_mode = M_HH; m_left = span(m_hh); end
              else m_left = m_sms * MS;
            end
          end
          M_HH: begin
            m_left--;
            if (m_left == 0) begin m_mode = M_FALL; m_left = m_sms * MS; end
          end
          M_FALL: begin
            m_left--;
            if (m_left == 0) begin
              m_duty = (m_duty - m_step < m_min) ? m_min : m_duty - m_step;
              if (m_duty == m_min) begin m_mode = M_HL; m_left = span(m_hl); end
              else m_left = m_sms * MS;
            end
          end
          default: begin
            m_left--;
            if (m_left == 0) begin
              m_done = 1;
              if (m_os != 0) begin m_mode = M_IDLE; m_duty = 0; end
              else begin m_mode = M_RISE; m_left = m_sms * MS; end
            end
          end
        endcase
      end
      m_busy = (m_mode != M_IDLE) ? 1 : 0;
    end
  end

  // Per-cycle comparison plus a log of duty changes and profile extremes.
  int dq[$];
  int ts[$];
  int prev_duty = 0;
  int done_cnt = 0;
  int max_seen = 0;
  int min_seen = 1000;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("duty", pwm_duty, m_duty);
      chk("busy", busy, m_busy);
      chk("cycle_done", cycle_done, m_done);
      chk("pwm_rate", pwm_rate, PWM_RATE);
      if (int'(pwm_duty) != prev_duty) begin
        dq.push_back(int'(pwm_duty));
        ts.push_back(cyc);
        prev_duty = int'(pwm_duty);
      end
      if (cycle_done) done_cnt++;
      if (busy) begin
        if (int'(pwm_duty) > max_seen) max_seen = int'(pwm_duty);
        if (int'(pwm_duty) < min_seen) min_seen = int'(pwm_duty);
      end
    end else begin
      prev_duty = 0;
    end
  end

  task automatic setup(input int mn, input int mx, input int st, input int sms,
                       input int hh, input int hl, input int os);
    duty_min   = 10'(mn);
    duty_max   = 10'(mx);
    duty_step  = 7'(st);
    step_ms    = 16'(sms);
    hold_hi_ms = 16'(hh);
    hold_lo_ms = 16'(hl);
    one_shot   = os[0];
  endtask

  task automatic clear_log();
    dq.delete();
    ts.delete();
    done_cnt = 0;
    max_seen = 0;
    min_seen = 1000;
  endtask

  // Runs until the end-of-cycle pulse, then drops en; output must already be off.
  task automatic run_one_shot(input string name, input int limit);
    int n;
    int got;
    n = 0; got = 0;
    while (n < limit && got == 0) begin
      @(negedge clk);
      n++;
      if (cycle_done) got = 1;
    end
    chk({name, "_done_seen"}, got, 1);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_duty"}, pwm_duty, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_seq(input string name, input int exp[$]);
    chk({name, "_len"}, dq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dq.size()) chk($sformatf("%s_val%0d", name, i), dq[i], exp[i]);
    end
  endtask

  initial begin
    int start;
    int n;
    int got;
    int exp_q[$];

    repeat (3) @(negedge clk);
    chk("rst_duty", pwm_duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", cycle_done, 0);
    chk("rst_rate", pwm_rate, PWM_RATE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic profile: 0..100 in steps of 25, 2 ms per step, 1 ms holds.
    clear_log();
    setup(0, 100, 25, 2, 1, 1, 1);
    start = cyc;
    en = 1'b1;
    run_one_shot("t1", 30000);
    exp_q = '{25, 50, 75, 100, 75, 50, 25, 0};
    chk_seq("t1_seq", exp_q);
    if (ts.size() >= 5) begin
      chk("t1_first_step", ts[0] - start, 2001);
      chk("t1_step_gap", ts[1] - ts[0], 2000);
      chk("t1_hold_gap", ts[4] - ts[3], 3000);
    end
    chk("t1_done_cnt", done_cnt, 1);

    // Clamping at both ends.
    clear_log();
    setup(10, 100, 30, 1, 0, 0, 1);
    en = 1'b1;
    run_one_shot("t2", 20000);
    exp_q = '{10, 40, 70, 100, 70, 40, 10, 0};
    chk_seq("t2_seq", exp_q);

    // Out-of-range configuration collapses to a flat 100 profile.
    clear_log();
    setup(120, 150, 0, 0, 0, 0, 1);
    en = 1'b1;
    run_one_shot("t3", 10000);
    exp_q = '{100, 0};
    chk_seq("t3_seq", exp_q);
    chk("t3_max_duty", max_seen, 100);

    // Free-running for three full cycles.
    clear_log();
    setup(20, 80, 60, 1, 0, 0, 0);
    en = 1'b1;
    n = 0;
    while (n < 20000 && done_cnt < 3) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_done_cnt", done_cnt, 3);
    chk("t4_max_duty", max_seen, 80);
    chk("t4_min_duty", min_seen, 20);

    // en dropped mid-rise, then reasserted.
    clear_log();
    setup(0, 100, 25, 1, 0, 0, 0);
    en = 1'b1;
    n = 0;
    while (n < 10000 && pwm_duty != 10'd50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_50", pwm_duty, 50);
    en = 1'b0;
    @(negedge clk);
    chk("t5_drop_duty", pwm_duty, 0);
    chk("t5_drop_busy", busy, 0);
    chk("t5_drop_done", cycle_done, 0);
    @(negedge clk);
    en = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (pwm_duty != 10'd25 && n < 5000);
    chk("t5_restart_latency", n, 1001);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_done_cnt", done_cnt, 0);

    // Asynchronous reset in the middle of the high dwell.
    clear_log();
    setup(0, 100, 50, 1, 3, 0, 1);
    en = 1'b1;
    n = 0;
    while (n < 10000 && pwm_duty != 10'd100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_100", pwm_duty, 100);
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_duty", pwm_duty, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", cycle_done, 0);
    chk("t6_rst_rate", pwm_rate, PWM_RATE);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Random configurations; inputs are scrambled while running and must
    // have no effect until the next start.
    for (int k = 0; k < 3; k++) begin
      setup($urandom_range(0, 150), $urandom_range(0, 150), $urandom_range(34, 127),
            $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 2), 1);
      en = 1'b1;
      n = 0; got = 0;
      while (n < 30000 && got == 0) begin
        @(negedge clk);
        n++;
        if (cycle_done) got = 1;
        else if (n % 300 == 0)
          setup($urandom_range(0, 150), $urandom_range(0, 150), $urandom_range(0, 127),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1));
      end
      chk($sformatf("rand%0d_done_seen", k), got, 1);
      en = 1'b0;
      repeat (3) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_breath_ctr.md
Name: pwm_breath_ctr

Overview:
Sequencer that drives the duty and rate inputs of the PWM generator to produce an LED "breathing" profile: ramp up, hold, ramp down, hold, repeat. It sits between the board-level control (switches/keys or a register block) and the pwm_ctr instance. All timing is in milliseconds, derived from a ms tick built from CLK_FRE.

Parameters:
CLK_FRE, 50, system clock in MHz; one ms tick every CLK_FRE*1000 cycles
PWM_RATE, 1000, PWM frequency in Hz driven constantly on pwm_rate (21-bit, max 500_000)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  level; 1 = run profile, 0 = stop and force output off
one_shot  input  1  1 = run a single up/down cycle then return to IDLE; sampled at start
duty_min  input  10  lower duty bound, percent 0..100; sampled at start
duty_max  input  10  upper duty bound, percent 0..100; sampled at start
duty_step  input  7  percent change per step; sampled at start
step_ms  input  16  ms between duty steps; sampled at start
hold_hi_ms  input  16  ms to dwell at duty_max; sampled at start
hold_lo_ms  input  16  ms to dwell at duty_min; sampled at start
pwm_duty  output  10  duty to pwm_ctr, percent 0..100
pwm_rate  output  21  rate to pwm_ctr, constant PWM_RATE
busy  output  1  1 whenever state != IDLE
cycle_done  output  1  one-clk pulse at end of each full up/down cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE, pwm_duty=0, busy=0, cycle_done=0, prescaler and ms counter = 0, shadow config = 0. pwm_rate is combinational constant PWM_RATE at all times.
- All outputs registered; pwm_duty changes one clk after the triggering event.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- IDLE: pwm_duty=0. When en=1, latch all config inputs into shadow registers, load pwm_duty=min_c, clear prescaler and ms counter, go RISE. Config changes while running have no effect until the next start.
- Shadow sanitising at latch: max_c = min(duty_max,100); min_c = min(duty_min, max_c); step_c = (duty_step==0)?1:duty_step; step_ms==0 is treated as 1.
- ms tick: prescaler counts 0..CLK_FRE*1000-1 only outside IDLE; tick = 1-clk pulse at terminal count, then wraps to 0.
- ms counter: increments on tick; when it reaches the active interval minus 1 on a tick, the interval expires; counter clears on expiry and on every state change.
- RISE: on each step_ms expiry, pwm_duty = min(pwm_duty+step_c, max_c) (compute in 11 bits, no overflow). On the same clk the update yields max_c -> HOLD_HI. If min_c==max_c, go to HOLD_HI on the first expiry.
- HOLD_HI: duty held at max_c for hold_hi_ms ms then -> FALL; hold_hi_ms==0 -> FALL on next clk.
- FALL: on each step_ms expiry, pwm_duty = max(pwm_duty-step_c, min_c), no underflow below 0 or min_c. Reaching min_c -> HOLD_LO.
- HOLD_LO: duty held at min_c for hold_lo_ms ms (0 = next clk). On exit pulse cycle_done for 1 clk; one_shot latched -> IDLE (pwm_duty=0), else -> RISE (duty stays min_c, counters cleared).
- en=0 in any state: next clk state IDLE, pwm_duty=0, busy=0, counters cleared, no cycle_done. This takes priority over every expiry in the same clk.
- en held 1 after a one_shot completes: IDLE re-latches and restarts on the next clk (en is a level, not an edge).
- Mid-operation reset: immediate async return to reset values.

Decomposition:
- Shared package/header: state encoding localparams, DUTY_FULL=100, MS_DIV = CLK_FRE*1000.
- One sub-module: ms_tick_gen (clk, rst_n, clr, tick), the prescaler with clear input. Everything else stays in pwm_breath_ctr.

Test Plan:
- CLK_FRE=1, min=0, max=100, step=25, step_ms=2, holds=1, one_shot=1, en=1 -> duty 0,25,50,75,100 at 2000-clk spacing; 100 held 1000 clks; falls to 0; cycle_done one pulse; busy falls; duty=0.
- step=30, max=100, min=10 -> rise 10,40,70,100 (clamped, not 130); fall 70,40,10 (clamped, not -20).
- duty_max=150, duty_min=120, duty_step=0, step_ms=0 -> max_c=min_c=100, step_c=1, step_ms=1 ms; duty 100 -> HOLD_HI directly, no value >100 ever driven.
- one_shot=0, en=1 for 3 cycles -> exactly 3 cycle_done pulses; duty never leaves [min_c,max_c].
- en dropped mid-RISE at duty=50 -> next clk duty=0, busy=0, no cycle_done; en reasserted -> restarts at min_c with full first step interval.
- rst_n pulsed low mid-HOLD_HI -> immediate duty=0, busy=0; pwm_rate stays PWM_RATE throughout.
